// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and loader status for imem_loader.
interface imem_loader_if #(
    parameter int unsigned AW = 5
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          core_hold;
    logic          load_done;
    logic          load_err;

    // Host / environment side
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, core_hold, load_done, load_err
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, core_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: parses SYNC/LEN/payload/CSUM frames from a byte
// stream, writes the payload into instruction memory and holds the core in
// reset while a frame is in flight.
module imem_loader #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus
);
    // Counter one bit wider than the address so a full-depth count fits.
    localparam int unsigned CW   = AW + 1;
    localparam logic [7:0]  SYNC = 8'hA5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [7:0]    sum_q, sum_d;

    logic          rx_ready_q;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          core_hold_q;
    logic          load_done_q;
    logic          load_err_q, load_err_d;

    logic          accept;
    logic          len_ok;

    assign accept = bus.rx_valid & rx_ready_q;
    assign len_ok = (bus.rx_data != 8'd0) && (9'(bus.rx_data) <= 9'(DEPTH));

    // Next-state, datapath and pulse decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sum_d      = sum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        load_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (bus.rx_data == SYNC)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_ok) begin
                        len_d   = CW'(bus.rx_data);
                        sum_d   = bus.rx_data;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_LOAD: begin
                // SYNC value here is ordinary payload; no mid-frame resync
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[AW-1:0];
                    wr_data_d = bus.rx_data;
                    cnt_d     = cnt_q + CW'(1);
                    sum_d     = sum_q + bus.rx_data;
                    if (cnt_d == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = S_END;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            rx_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            core_hold_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            rx_ready_q  <= (state_d != S_END);
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            // Hold stays up through the error pulse so it falls the cycle after
            core_hold_q <= (state_d != S_IDLE) | load_err_d;
            load_done_q <= (state_d == S_END);
            load_err_q  <= load_err_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.core_hold = core_hold_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes go into a scoreboard
// when a payload byte is handed over and are matched against wr_en cycles.
module tb_imem_loader;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam logic [7:0]  SYNC  = 8'hA5;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         tag;
    } wr_t;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   done_cnt;
    int   err_cnt;
    wr_t  sb_q[$];

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/pulse monitor: every write must match the scoreboard head one cycle after its handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.load_done) done_cnt++;
            if (bus.load_err) err_cnt++;
            n_checks++;
            if (bus.load_done && bus.load_err) begin
                n_fail++;
                $display("FAIL done_err_exclusive: load_done=%b load_err=%b, required not both", bus.load_done, bus.load_err);
            end
            if (sb_q.size() != 0 && sb_q[0].tag < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_missing: no write for addr %0d data %02h at cycle %0d", sb_q[0].addr, sb_q[0].data, sb_q[0].tag);
                void'(sb_q.pop_front());
            end
            if (bus.wr_en) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: addr %0d data %02h, required no write", bus.wr_addr, bus.wr_data);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    if (bus.wr_addr !== AW'(e.addr) || bus.wr_data !== e.data || e.tag != cyc) begin
                        n_fail++;
                        $display("FAIL wr_match: got addr %0d data %02h cycle %0d, required addr %0d data %02h cycle %0d",
                                 bus.wr_addr, bus.wr_data, cyc, e.addr, e.data, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Idle cycles with rx_valid low; called and returns at posedge+1
    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte until accepted; queue its expected write if it is payload
    task automatic send_byte(input logic [7:0] b, input bit exp_wr, input int addr);
        bit taken;
        int guard;
        taken = 1'b0;
        guard = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!taken && guard < 20) begin
            taken = bus.rx_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!taken) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_ready_timeout: byte %02h not accepted in 20 cycles, required accept", b);
        end else if (exp_wr) begin
            sb_q.push_back('{addr: addr, data: b, tag: cyc});
        end
        bus.rx_valid = 1'b0;
    endtask

    // Full frame with optional random gaps; writes expected only for legal lengths
    task automatic send_frame(input logic [7:0] len, input byte_q_t pl, input logic [7:0] csum, input int max_gap);
        bit legal;
        legal = (len != 8'd0) && (int'(len) <= int'(DEPTH));
        send_byte(SYNC, 1'b0, 0);
        idle($urandom_range(0, max_gap));
        send_byte(len, 1'b0, 0);
        for (int i = 0; i < pl.size(); i++) begin
            idle($urandom_range(0, max_gap));
            send_byte(pl[i], legal, i);
        end
        idle($urandom_range(0, max_gap));
        send_byte(csum, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b1 || bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus: rx_ready=%b wr_en=%b wr_addr=%0d wr_data=%02h, required 1 0 0 00",
                     bus.rx_ready, bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_checks++;
        if (bus.core_hold !== 1'b0 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: core_hold=%b load_done=%b load_err=%b, required 0 0 0",
                     bus.core_hold, bus.load_done, bus.load_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(SYNC, 1'b0, 0);
        n_checks++;
        if (bus.core_hold !== 1'b1 || bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL good_hold_len: core_hold=%b rx_ready=%b, required 1 1", bus.core_hold, bus.rx_ready);
        end
        send_byte(8'h04, 1'b0, 0);
        send_byte(8'h13, 1'b1, 0);
        send_byte(8'h00, 1'b1, 1);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h00, 1'b1, 3);
        send_byte(8'h17, 1'b0, 0);
        n_checks++;
        if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0 || bus.core_hold !== 1'b1 || bus.rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL good_end: done=%b err=%b hold=%b ready=%b, required 1 0 1 0",
                     bus.load_done, bus.load_err, bus.core_hold, bus.rx_ready);
        end
        idle(1);
        n_checks++;
        if (bus.load_done !== 1'b0 || bus.core_hold !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL good_after: done=%b hold=%b ready=%b, required 0 0 1", bus.load_done, bus.core_hold, bus.rx_ready);
        end
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== AW'(3) || bus.wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL good_hold_wr: wr_en=%b wr_addr=%0d wr_data=%02h, required 0 3 00", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL good_pulses: done=%0d err=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_bad_csum();
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 1);
        send_byte(8'h00, 1'b0, 0);
        n_checks++;
        if (bus.load_err !== 1'b1 || bus.load_done !== 1'b0 || bus.core_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL badcs_err: err=%b done=%b hold=%b, required 1 0 1", bus.load_err, bus.load_done, bus.core_hold);
        end
        idle(1);
        n_checks++;
        if (bus.load_err !== 1'b0 || bus.core_hold !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL badcs_after: err=%b hold=%b ready=%b, required 0 0 1", bus.load_err, bus.core_hold, bus.rx_ready);
        end
        n_checks++;
        if (done_cnt != d0 || err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL badcs_pulses: done=%0d err=%0d, required 0 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_illegal_len();
        int e0;
        logic [7:0] lens[2];
        e0 = err_cnt;
        lens[0] = 8'h00;
        lens[1] = 8'h21;
        for (int k = 0; k < 2; k++) begin
            send_byte(SYNC, 1'b0, 0);
            send_byte(lens[k], 1'b0, 0);
            n_checks++;
            if (bus.load_err !== 1'b1 || bus.wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL badlen_err_%02h: err=%b wr_en=%b, required 1 0", lens[k], bus.load_err, bus.wr_en);
            end
            idle(1);
            n_checks++;
            if (bus.core_hold !== 1'b0 || bus.load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL badlen_after_%02h: hold=%b err=%b, required 0 0", lens[k], bus.core_hold, bus.load_err);
            end
        end
        n_checks++;
        if (err_cnt - e0 != 2) begin
            n_fail++;
            $display("FAIL badlen_pulses: err=%0d, required 2", err_cnt - e0);
        end
    endtask

    task automatic test_stalls_noise();
        int d0;
        byte_q_t pl;
        d0 = done_cnt;
        send_byte(8'h7F, 1'b0, 0);
        idle(1);
        send_byte(8'h3C, 1'b0, 0);
        n_checks++;
        if (bus.core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL noise_hold: core_hold=%b, required 0", bus.core_hold);
        end
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(8'h04, pl, 8'h17, 3);
        idle(2);
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL stall_done: done=%0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_full_depth();
        int d0;
        byte_q_t pl;
        logic [7:0] sum;
        d0 = done_cnt;
        sum = 8'h20;
        for (int i = 0; i < 32; i++) begin
            pl.push_back(8'(i * 37 + 5));
            sum = sum + 8'(i * 37 + 5);
        end
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'h20, 1'b0, 0);
        for (int i = 0; i < 32; i++) send_byte(pl[i], 1'b1, i);
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(31)) begin
            n_fail++;
            $display("FAIL full_last_addr: wr_en=%b wr_addr=%0d, required 1 31", bus.wr_en, bus.wr_addr);
        end
        send_byte(sum, 1'b0, 0);
        n_checks++;
        if (bus.load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done: load_done=%b, required 1", bus.load_done);
        end
        idle(1);
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL full_pulses: done=%0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        byte_q_t pl;
        d0 = done_cnt;
        // Payload containing SYNC values, then a second frame offered during END
        pl = '{SYNC, SYNC, 8'h01};
        send_frame(8'h03, pl, 8'h4E, 0);
        pl = '{8'h10, 8'h20};
        send_frame(8'h02, pl, 8'h32, 0);
        idle(1);
        n_checks++;
        if (done_cnt - d0 != 2 || bus.core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: done=%0d hold=%b, required 2 0", done_cnt - d0, bus.core_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        int d0;
        int e0;
        byte_q_t pl;
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'h04, 1'b0, 0);
        send_byte(8'h13, 1'b1, 0);
        send_byte(8'h00, 1'b1, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b1 || bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== 8'h00 ||
            bus.core_hold !== 1'b0 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_values: ready=%b wr_en=%b addr=%0d data=%02h hold=%b done=%b err=%b, required 1 0 0 00 0 0 0",
                     bus.rx_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.core_hold, bus.load_done, bus.load_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        e0 = err_cnt;
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(8'h04, pl, 8'h17, 0);
        idle(1);
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL midrst_reload: done=%0d err=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_illegal_len();
        test_stalls_noise();
        test_full_depth();
        test_back_to_back();
        test_reset_mid_load();
        idle(4);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d writes outstanding, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32: instruction memory size in bytes; power of two, 2..256.
REQ-002 Parameter AW, default $clog2(DEPTH): write address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  incoming byte from host stream.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts the byte this cycle; a byte transfers when rx_valid && rx_ready.
REQ-008 wr_en  output  1  one-cycle byte write strobe to instruction memory.
REQ-009 wr_addr  output  AW  byte address of the write.
REQ-010 wr_data  output  8  byte to write.
REQ-011 core_hold  output  1  high while a load frame is in progress; holds the core and PC in reset.
REQ-012 load_done  output  1  one-cycle pulse when a frame completes with a good checksum.
REQ-013 load_err  output  1  one-cycle pulse when a frame is aborted or the checksum fails.

Function
REQ-014 Frame format: SYNC byte 0xA5, then LEN byte, then LEN payload bytes, then CSUM byte.
REQ-015 CSUM shall equal the 8-bit sum, mod 256, of the LEN byte and all payload bytes.
REQ-016 States shall be IDLE, LEN, LOAD, CSUM and END.
REQ-017 IDLE: an accepted 0xA5 goes to LEN; any other accepted byte is discarded and the state stays IDLE.
REQ-018 LEN, legal value (1..DEPTH): store the length, set the running sum to LEN, clear the address counter, go to LOAD.
REQ-019 LEN, illegal value (0 or greater than DEPTH): pulse load_err and return to IDLE; no writes.
REQ-020 LOAD: each accepted byte produces wr_en=1 on the next cycle, with wr_addr = counter and wr_data = byte.
REQ-021 LOAD: after each accepted byte, the counter increments and the sum accumulates mod 256.
REQ-022 LOAD: the byte that makes the count equal the length moves the state to CSUM.
REQ-023 Write latency: exactly one cycle from the handshake to wr_en.
REQ-024 wr_en shall never be asserted outside LOAD-accepted bytes.
REQ-025 Throughput: one byte per cycle; rx_valid gaps stall the FSM with no side effects.
REQ-026 CSUM: an accepted byte matching the sum goes to END.
REQ-027 CSUM: on a mismatch, pulse load_err on the next cycle and return to IDLE; bytes already written remain in memory.
REQ-028 END lasts one cycle: load_done pulses and the state returns to IDLE.
REQ-029 load_done and load_err shall never be asserted together.
REQ-030 rx_ready shall be 1 in IDLE, LEN, LOAD and CSUM, and 0 in END.
REQ-031 core_hold shall be 1 in LEN, LOAD, CSUM and END.
REQ-032 core_hold shall be 0 in IDLE, deasserting the cycle after load_done or load_err.
REQ-033 A 0xA5 received in LOAD or CSUM is treated as data; there is no resync mid-frame.
REQ-034 Address counter width shall be AW+1 so that a count of DEPTH is representable; wr_addr never wraps within a frame.
REQ-035 wr_addr and wr_data shall hold their last value when wr_en=0.

Reset
REQ-036 While reset_n=0, the FSM shall be in IDLE; all other reset values follow REQ-037 to REQ-039.
REQ-037 Reset values: rx_ready=1, wr_en=0, wr_addr=0, wr_data=0.
REQ-038 Reset values: core_hold=0, load_done=0, load_err=0.
REQ-039 Reset values: counter=0, stored length=0, sum=0.
REQ-040 Reset asserted mid-frame aborts the frame immediately, with no load_err pulse and no further writes.
REQ-041 After reset_n rises, the first rising edge shall be usable.

Verification
REQ-042 Good frame: stream A5 04 13 00 00 00 17 at one byte/cycle -> writes (0,13)(1,00)(2,00)(3,00) on consecutive cycles; load_done pulses once; core_hold falls the next cycle.
REQ-043 Bad checksum: stream A5 02 11 22 00 -> two writes, then load_err pulses, load_done stays 0, state returns to IDLE.
REQ-044 Illegal length: stream A5 00, then separately A5 21 with DEPTH=32 -> load_err pulses for each; wr_en is never asserted.
REQ-045 Stalls and noise: stream 7F 3C then a good frame with random rx_valid gaps -> leading bytes discarded; writes match REQ-042 addresses and data; no duplicate writes.
REQ-046 Full depth: LEN=0x20 followed by 32 bytes -> last write at wr_addr=31; correct CSUM gives load_done.
REQ-047 Reset mid-LOAD: drop reset_n after the 2nd payload byte -> outputs take reset values asynchronously; a following good frame loads correctly.
